// File: rtl/ram16_drain_ctrl.sv
// Drains RAM16 after each fill: reads every word in address order and streams it
// out over valid/ready, with last marker, frame checksum and sticky overrun flag.
module ram16_drain_ctrl #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  full_i,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_a,
  input  logic [15:0]           ram_do,
  output logic [15:0]           m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clr_ovr,
  output logic [15:0]           frame_sum
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] ram_a_reg, ram_a_next;
  logic [15:0]           m_data_reg, m_data_next;
  logic                  m_valid_reg, m_valid_next;
  logic                  m_last_reg, m_last_next;
  logic                  overrun_reg, overrun_next;
  logic [15:0]           frame_sum_reg, frame_sum_next;
  logic                  full_prev_reg;

  logic rise;
  logic handshake;
  logic final_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      ram_a_reg     <= '0;
      m_data_reg    <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_sum_reg <= '0;
      full_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      ram_a_reg     <= ram_a_next;
      m_data_reg    <= m_data_next;
      m_valid_reg   <= m_valid_next;
      m_last_reg    <= m_last_next;
      overrun_reg   <= overrun_next;
      frame_sum_reg <= frame_sum_next;
      full_prev_reg <= full_i;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    ram_a_next     = ram_a_reg;
    m_data_next    = m_data_reg;
    m_valid_next   = m_valid_reg;
    m_last_next    = m_last_reg;
    frame_sum_next = frame_sum_reg;

    rise      = full_i & ~full_prev_reg;
    handshake = m_valid_reg & m_ready;
    final_hs  = (state_reg == OUT) && handshake && (addr_reg == LAST_ADDR);

    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next     = RD;
          addr_next      = '0;
          ram_a_next     = '0;
          frame_sum_next = '0;
        end
      end
      RD: state_next = CAP;
      CAP: begin
        m_data_next  = ram_do;
        m_valid_next = 1'b1;
        m_last_next  = (addr_reg == LAST_ADDR);
        state_next   = OUT;
      end
      OUT: begin
        if (handshake) begin
          frame_sum_next = frame_sum_reg + m_data_reg;
          m_valid_next   = 1'b0;
          m_last_next    = 1'b0;
          if (addr_reg != LAST_ADDR) begin
            addr_next  = addr_reg + ADDR_ONE;
            ram_a_next = addr_reg + ADDR_ONE;
            state_next = RD;
          end else if (rise) begin
            // back-to-back frame: the new fill is accepted on the closing beat
            addr_next      = '0;
            ram_a_next     = '0;
            frame_sum_next = '0;
            state_next     = RD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // a dropped fill must be reported even if software clears in the same cycle
    if (rise && (state_reg != IDLE) && !final_hs) begin
      overrun_next = 1'b1;
    end else if (clr_ovr) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun_reg;
    end
  end

  assign ram_read  = (state_reg == RD);
  assign busy      = (state_reg != IDLE);
  assign ram_a     = ram_a_reg;
  assign m_data    = m_data_reg;
  assign m_valid   = m_valid_reg;
  assign m_last    = m_last_reg;
  assign overrun   = overrun_reg;
  assign frame_sum = frame_sum_reg;

endmodule

// File: tb/tb_ram16_drain_ctrl.sv
// Scoreboard bench for ram16_drain_ctrl: a frame-level model queues expected beats,
// a separate monitor pops and compares every accepted output beat.
module tb_ram16_drain_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          full_i;
  logic          ram_read;
  logic [AW-1:0] ram_a;
  logic [15:0]   ram_do = 16'h0;
  logic [15:0]   m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          overrun;
  logic          clr_ovr;
  logic [15:0]   frame_sum;

  always #5 clk = ~clk;

  ram16_drain_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .full_i    (full_i),
    .ram_read  (ram_read),
    .ram_a     (ram_a),
    .ram_do    (ram_do),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr),
    .frame_sum (frame_sum)
  );

  // RAM16 read port: data appears the cycle after READ is sampled
  logic [15:0] mem [DEPTH];
  always @(posedge clk) if (ram_read) ram_do <= mem[ram_a];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [15:0] data; logic last; } beat_t;
  beat_t sb_q[$];

  // frame-level reference: remaining beats of the frame being drained
  int          remaining = 0;
  logic [15:0] frame_words [DEPTH];
  logic [15:0] sum_exp = 16'h0;
  logic        ovr_exp = 1'b0;
  logic        fp = 1'b0;
  logic        read_done = 1'b0;
  logic        rise_m, hs_m, acc_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      remaining = 0;
      sb_q.delete();
      ovr_exp   = 1'b0;
      sum_exp   = 16'h0;
      fp        = 1'b0;
      read_done = 1'b0;
    end else begin
      check("busy", busy, remaining > 0);
      check("overrun", overrun, ovr_exp);
      check("frame_sum", frame_sum, sum_exp);
      if (ram_read) begin
        check("ram_a", ram_a, DEPTH - remaining);
        check("read_once", read_done, 1'b0);
        check("read_in_stall", m_valid, 1'b0);
        read_done = 1'b1;
      end
      hs_m   = m_valid && m_ready;
      rise_m = full_i && !fp;
      fp     = full_i;
      acc_m  = rise_m && (remaining == 0 || (remaining == 1 && hs_m));
      if (hs_m && remaining > 0) begin
        sum_exp   = sum_exp + frame_words[DEPTH - remaining];
        remaining = remaining - 1;
        read_done = 1'b0;
      end
      if (rise_m && !acc_m) ovr_exp = 1'b1;
      else if (clr_ovr)     ovr_exp = 1'b0;
      if (acc_m) begin
        remaining = DEPTH;
        sum_exp   = 16'h0;
        for (int k = 0; k < DEPTH; k++) begin
          frame_words[k] = mem[k];
          sb_q.push_back(beat_t'{data: mem[k], last: (k == DEPTH - 1)});
        end
      end
    end
  end

  logic [15:0] hold_data;
  logic        hold_last;
  logic        holding = 1'b0;
  beat_t       got;

  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, hold_data);
        check("stall_last", m_last, hold_last);
      end
      if (m_valid && m_ready) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got data %h with no expected beat queued", m_data);
        end else begin
          got = sb_q.pop_front();
          $display("beat data=%h last=%b (expected %h/%b)", m_data, m_last, got.data, got.last);
          if (m_data !== got.data || m_last !== got.last) begin
            miscompares++;
            $display("FAIL beat: got %h/%b expected %h/%b", m_data, m_last, got.data, got.last);
          end
        end
        holding = 1'b0;
      end else if (m_valid) begin
        holding   = 1'b1;
        hold_data = m_data;
        hold_last = m_last;
      end else begin
        holding = 1'b0;
      end
    end
  end

  int ready_mode = 0;
  int cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = (cyc % 3 == 0);
      2: m_ready = ($urandom_range(0, 2) != 0);
      default: ;
    endcase
  endtask

  task automatic fill(input logic [15:0] base);
    for (int k = 0; k < DEPTH; k++) mem[k] = base + 16'(k);
  endtask

  task automatic pulse_full();
    full_i = 1'b1;
    tick();
    full_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (remaining == 0 && sb_q.size() == 0) begin ok = 1; break; end
    end
    check("idle_timeout", ok, 1'b1);
  endtask

  task automatic wait_rem(input int n, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (remaining == n && m_valid) begin ok = 1; break; end
    end
    check("wait_timeout", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; full_i = 1'b0; m_ready = 1'b0; clr_ovr = 1'b0;
    fill(16'hB000);
    repeat (3) tick();
    check("rst_valid", m_valid, 1'b0);
    check("rst_read", ram_read, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_sum", frame_sum, 16'h0);
    check("rst_data", m_data, 16'h0);
    check("rst_last", m_last, 1'b0);
    check("rst_addr", ram_a, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // full-rate frame
    pulse_full();
    wait_idle(100);
    check("f1_sum", frame_sum, 16'h801C);
    check("f1_busy", busy, 1'b0);
    check("f1_ovr", overrun, 1'b0);

    // 1-on/2-off backpressure
    ready_mode = 1;
    pulse_full();
    wait_idle(300);
    check("f2_sum", frame_sum, 16'h801C);

    // second fill
    ready_mode = 0;
    fill(16'hB008);
    pulse_full();
    wait_idle(100);
    check("f3_sum", frame_sum, 16'h805C);

    // overrun while draining word 3, then clear
    fill(16'hB000);
    pulse_full();
    wait_rem(DEPTH - 3, 100);
    pulse_full();
    wait_idle(100);
    repeat (5) tick();
    check("ovr_set", overrun, 1'b1);
    check("ovr_idle", busy, 1'b0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    pulse_full();
    wait_rem(DEPTH - 2, 100);
    full_i = 1'b1; clr_ovr = 1'b1;
    tick();
    full_i = 1'b0; clr_ovr = 1'b0;
    tick();
    check("ovr_set_wins", overrun, 1'b1);
    wait_idle(100);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // fill arriving with the closing handshake
    ready_mode = 3;
    m_ready = 1'b1;
    fill(16'hB010);
    pulse_full();
    begin
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (m_valid && m_last) begin ok = 1; break; end
      end
      check("last_timeout", ok, 1'b1);
    end
    fill(16'hB018);
    full_i = 1'b1;
    tick();
    full_i = 1'b0;
    check("b2b_read", ram_read, 1'b1);
    check("b2b_addr", ram_a, 0);
    ready_mode = 0;
    wait_idle(100);
    check("b2b_ovr", overrun, 1'b0);
    check("b2b_sum", frame_sum, 16'h80DC);

    // reset in the middle of word 5
    pulse_full();
    wait_rem(DEPTH - 5, 100);
    rst_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 1'b0);
    check("arst_read", ram_read, 1'b0);
    check("arst_busy", busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("rel_idle", busy, 1'b0);
    rst_n = 1'b0;
    full_i = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rel_full_read", ram_read, 1'b1);
    check("rel_full_addr", ram_a, 0);
    wait_idle(100);
    full_i = 1'b0;
    tick();

    // randomized fills, backpressure and clears
    ready_mode = 2;
    for (int i = 0; i < 600; i++) begin
      full_i  = ($urandom_range(0, 7) == 0);
      clr_ovr = ($urandom_range(0, 15) == 0);
      if (remaining == 0 && !full_i)
        for (int k = 0; k < DEPTH; k++) mem[k] = 16'($urandom);
      tick();
    end
    full_i = 1'b0; clr_ovr = 1'b0;
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram16_drain_ctrl.md
Name: ram16_drain_ctrl

Overview:
Downstream read-out stage for the RAM16 buffer. It watches RAM16's FULL indication, and on each fill event it reads all DEPTH words in address order 0..DEPTH-1 through RAM16's READ/A/Do port. Each word is presented on a valid/ready output stream that supports backpressure, with a last-word marker, a per-frame checksum and a sticky overrun flag.

Parameters:
ADDR_WIDTH, 3, RAM16 address width; DEPTH = 2**ADDR_WIDTH words per frame (must match the RAM16 instance).

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  reset, asynchronous, active-low.
FULL_I  in  1  FULL output of RAM16; a rising edge marks a completed fill of DEPTH words.
RAM_READ  out  1  READ strobe to RAM16.
RAM_A  out  ADDR_WIDTH  address to RAM16 A.
RAM_DO  in  16  RAM16 Do; valid in the cycle after RAM_READ is sampled high, held until the next read.
M_DATA  out  16  output word.
M_VALID  out  1  output word valid.
M_LAST  out  1  high with the final word (address DEPTH-1) of a frame.
M_READY  in  1  downstream accept.
BUSY  out  1  high whenever the state is not IDLE.
OVERRUN  out  1  sticky; a fill event arrived while a drain was in progress.
CLR_OVR  in  1  synchronous clear of OVERRUN.
FRAME_SUM  out  16  sum mod 2^16 of the words accepted in the current or most recent frame.

Behaviour:
- Reset (async, RST_N=0): state IDLE, addr=0, RAM_READ=0, RAM_A=0, M_DATA=0, M_VALID=0, M_LAST=0, OVERRUN=0, FRAME_SUM=0, full_prev=0.
- Edge detect: rise = FULL_I & ~full_prev, with full_prev registered every cycle. Because full_prev resets to 0, a FULL_I already high at reset release counts as a rise.
- FSM states: IDLE, RD, CAP, OUT.
  - IDLE: on rise, go to RD with addr=0 and FRAME_SUM cleared to 0.
  - RD: RAM_READ=1 for exactly one cycle with RAM_A=addr; go to CAP.
  - CAP: RAM_READ=0. Register RAM_DO into M_DATA, set M_VALID=1, set M_LAST=(addr==DEPTH-1); go to OUT.
  - OUT: hold M_DATA, M_VALID and M_LAST stable while M_READY=0.
  - OUT handshake (M_VALID & M_READY): FRAME_SUM += M_DATA (16-bit wrap). M_VALID drops next cycle. If addr<DEPTH-1, addr++ and go to RD. If addr==DEPTH-1, go to IDLE.
- Latency: first M_VALID rises 3 cycles after the FULL_I rise is sampled. Best-case throughput is 1 word per 3 cycles with M_READY held high. A full frame drain is 3*DEPTH cycles minimum.
- RAM_A equals addr during RD and holds its last value otherwise. RAM_READ is never high outside RD.
- Overrun: a rise in RD, CAP, or in OUT other than the final handshake sets OVERRUN=1. That fill event is dropped; no frame is queued, and the current drain continues unaffected.
- Rise coincident with the final handshake (OUT, addr==DEPTH-1, M_READY=1): accepted as a new frame. Go directly to RD with addr=0 and FRAME_SUM reset to 0; OVERRUN is not set.
- CLR_OVR=1 clears OVERRUN next cycle. If an overrun occurs in the same cycle, set wins.
- FRAME_SUM is stable in IDLE and reflects the last completed frame.
- The block does not arbitrate against concurrent RAM16 writes. Words read are whatever RAM16 holds at each RD cycle.
- RST_N asserted mid-drain: abort immediately to reset values. No partial-frame resumption.

Test Plan:
- Reset, then FULL_I pulse with RAM16 holding B000..B007 and M_READY=1 -> 8 beats B000..B007 in order, M_LAST only on B007, FRAME_SUM=0x801C, BUSY low after the last beat, OVERRUN=0.
- Same frame with M_READY toggling 1 cycle on / 2 cycles off -> identical data sequence, M_DATA and M_LAST stable while stalled, no RAM_READ issued during a stall, FRAME_SUM=0x801C.
- Second fill B008..B00F after the first frame completes -> second frame delivered, FRAME_SUM=0x805C, exactly 8 RAM_READ pulses per frame with RAM_A stepping 0..7.
- FULL_I pulse while draining word 3 -> OVERRUN=1, only 8 beats are output, and the block then returns to IDLE. CLR_OVR pulse gives OVERRUN=0; CLR_OVR in the same cycle as a new overrun leaves OVERRUN=1.
- FULL_I rise in the same cycle as the B007 handshake -> RD is entered next cycle with RAM_A=0, a new frame begins, OVERRUN stays 0.
- RST_N pulled low during word 5 of a frame -> M_VALID, RAM_READ and BUSY go to 0 asynchronously. After release with FULL_I low, the block stays IDLE; with FULL_I held high at release, a new frame starts at address 0.
